fp_add_sequencer: RTL and testbench

Control FSM that sequences one 32-bit floating-point add/subtract through the two-phase normalise-then-add datapath. It accepts one request at a time over a start/ready handshake and registers the operands. It then drives the datapath enable, normaliser-load and adder-load strobes, waits for the normaliser output-enable, and holds the signed result until the requester acknowledges it. A watchdog flags a hung normaliser.

---
 rtl/fp_add_sequencer.sv | 149 ++++++++++++++
 tb/tb_fp_add_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// Control FSM for one floating-point add/subtract through a normalise-then-add datapath.
// Operands are latched on accept; the result is held until acknowledged.
module fp_add_sequencer #(
   parameter int unsigned NORM_TIMEOUT = 32,
   parameter int unsigned ADD_LAT      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op_sub,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        ready,
   output logic        dp_en,
   output logic        dp_loadN,
   output logic        dp_loadA,
   output logic        dp_sub,
   output logic [31:0] dp_a,
   output logic [31:0] dp_b,
   input  logic        dp_norm_oe,
   input  logic [31:0] dp_sum,
   input  logic        dp_cout,
   output logic [31:0] result,
   output logic        result_cout,
   output logic        result_err,
   output logic        result_valid,
   input  logic        result_ack
);

   // One counter serves both the NORM watchdog and the ADD latency.
   localparam int unsigned CntMax = (NORM_TIMEOUT > ADD_LAT) ? NORM_TIMEOUT : ADD_LAT;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] NormLast = CntW'(NORM_TIMEOUT - 1);
   localparam logic [CntW-1:0] AddLast  = CntW'(ADD_LAT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoadN,
      StNorm,
      StLoadA,
      StAdd,
      StDone
   } state_e;

   state_e            r_state, w_state_nxt;
   logic [CntW-1:0]   r_cnt, w_cnt_nxt;
   logic [31:0]       r_dp_a, w_dp_a_nxt;
   logic [31:0]       r_dp_b, w_dp_b_nxt;
   logic              r_dp_sub, w_dp_sub_nxt;
   logic [31:0]       r_result, w_result_nxt;
   logic              r_cout, w_cout_nxt;
   logic              r_err, w_err_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_dp_a   <= '0;
         r_dp_b   <= '0;
         r_dp_sub <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_dp_a   <= w_dp_a_nxt;
         r_dp_b   <= w_dp_b_nxt;
         r_dp_sub <= w_dp_sub_nxt;
         r_result <= w_result_nxt;
         r_cout   <= w_cout_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_dp_a_nxt   = r_dp_a;
      w_dp_b_nxt   = r_dp_b;
      w_dp_sub_nxt = r_dp_sub;
      w_result_nxt = r_result;
      w_cout_nxt   = r_cout;
      w_err_nxt    = r_err;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_dp_a_nxt   = a;
               w_dp_b_nxt   = b;
               w_dp_sub_nxt = op_sub;
               w_err_nxt    = 1'b0;
               w_state_nxt  = StLoadN;
            end
         end
         StLoadN: begin
            w_cnt_nxt   = '0;
            w_state_nxt = StNorm;
         end
         StNorm: begin
            // A late norm_oe on the final allowed cycle still beats the watchdog.
            if (dp_norm_oe) begin
               w_state_nxt = StLoadA;
            end else if (r_cnt == NormLast) begin
               w_result_nxt = '0;
               w_cout_nxt   = 1'b0;
               w_err_nxt    = 1'b1;
               w_state_nxt  = StDone;
            end else begin
               w_cnt_nxt = r_cnt + CntW'(1);
            end
         end
         StLoadA: begin
            w_cnt_nxt   = '0;
            w_state_nxt = StAdd;
         end
         StAdd: begin
            if (r_cnt == AddLast) begin
               w_result_nxt = dp_sum;
               w_cout_nxt   = dp_cout;
               w_state_nxt  = StDone;
            end else begin
               w_cnt_nxt = r_cnt + CntW'(1);
            end
         end
         StDone: begin
            if (result_ack) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign ready        = (r_state == StIdle);
   assign dp_en        = (r_state == StLoadN) || (r_state == StNorm) ||
                         (r_state == StLoadA) || (r_state == StAdd);
   assign dp_loadN     = (r_state == StLoadN);
   assign dp_loadA     = (r_state == StLoadA);
   assign result_valid = (r_state == StDone);
   assign dp_sub       = r_dp_sub;
   assign dp_a         = r_dp_a;
   assign dp_b         = r_dp_b;
   assign result       = r_result;
   assign result_cout  = r_cout;
   assign result_err   = r_err;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench: two sequencer instances (short watchdog / ADD_LAT=3) driven with
// directed transactions; a monitor checks each held result against queued expectations.
`timescale 1ns/1ps
module tb_fp_add_sequencer;

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        err;
      int          cyc;
      logic        sub;
      logic [31:0] a;
      logic [31:0] b;
      int          n_loada;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start [2];
   logic        op_sub = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        dp_norm_oe = 1'b0;
   logic [31:0] dp_sum = '0;
   logic        dp_cout = 1'b0;
   logic        result_ack = 1'b0;

   logic        ready [2];
   logic        dp_en [2];
   logic        dp_loadn [2];
   logic        dp_loada [2];
   logic        dp_sub [2];
   logic [31:0] dp_a [2];
   logic [31:0] dp_b [2];
   logic [31:0] result [2];
   logic        result_cout [2];
   logic        result_err [2];
   logic        result_valid [2];

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t sb0[$];
   exp_t sb1[$];

   fp_add_sequencer #(.NORM_TIMEOUT(4), .ADD_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .op_sub(op_sub), .a(a), .b(b),
      .ready(ready[0]), .dp_en(dp_en[0]), .dp_loadN(dp_loadn[0]), .dp_loadA(dp_loada[0]),
      .dp_sub(dp_sub[0]), .dp_a(dp_a[0]), .dp_b(dp_b[0]), .dp_norm_oe(dp_norm_oe),
      .dp_sum(dp_sum), .dp_cout(dp_cout), .result(result[0]), .result_cout(result_cout[0]),
      .result_err(result_err[0]), .result_valid(result_valid[0]), .result_ack(result_ack)
   );

   fp_add_sequencer #(.NORM_TIMEOUT(32), .ADD_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .op_sub(op_sub), .a(a), .b(b),
      .ready(ready[1]), .dp_en(dp_en[1]), .dp_loadN(dp_loadn[1]), .dp_loadA(dp_loada[1]),
      .dp_sub(dp_sub[1]), .dp_a(dp_a[1]), .dp_b(dp_b[1]), .dp_norm_oe(dp_norm_oe),
      .dp_sum(dp_sum), .dp_cout(dp_cout), .result(result[1]), .result_cout(result_cout[1]),
      .result_err(result_err[1]), .result_valid(result_valid[1]), .result_ack(result_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int d, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, got, exp, $time);
      end
   endtask

   // Issue one transaction; returns one cycle past the edge that enters DONE (or watchdog).
   task automatic run_txn(input int d, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsub, input int oe_cyc, input logic [31:0] s0,
                          input logic [31:0] s1, input logic [31:0] s2, input logic tcout,
                          input logic [31:0] exp_res, input logic exp_cout, input logic exp_err);
      exp_t e;
      int   ntmo, alat, n;
      ntmo = (d == 0) ? 4 : 32;
      alat = (d == 0) ? 1 : 3;
      chk("accept_ready", d, ready[d], 1);
      a = ta; b = tb; op_sub = tsub;
      dp_norm_oe = 1'b0; dp_sum = 32'h1234_5678; dp_cout = tcout;
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      // Scramble inputs to prove the operands were latched.
      a = 32'hA5A5_0000 ^ ta; b = 32'h5A5A_0000 ^ tb; op_sub = ~tsub;
      e.res = exp_res; e.cout = exp_cout; e.err = exp_err;
      e.cyc = cyc + ((oe_cyc > 0) ? (2 + oe_cyc + alat) : (1 + ntmo));
      e.sub = tsub; e.a = ta; e.b = tb; e.n_loada = (oe_cyc > 0) ? 1 : 0;
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      @(posedge clk); #1;
      n = (oe_cyc > 0) ? oe_cyc : ntmo;
      for (int c = 1; c <= n; c++) begin
         dp_norm_oe = (c == oe_cyc);
         chk("norm_dp_sub", d, dp_sub[d], tsub);
         @(posedge clk); #1;
      end
      dp_norm_oe = 1'b0;
      if (oe_cyc > 0) begin
         for (int j = 0; j < alat; j++) begin
            @(posedge clk); #1;
            dp_sum = (j == 0) ? s0 : ((j == 1) ? s1 : s2);
         end
         @(posedge clk); #1;
      end
      dp_sum = 32'h0BAD_F00D;
   endtask

   task automatic do_ack(input int d);
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
      chk("ack_ready", d, ready[d], 1);
      chk("ack_valid", d, result_valid[d], 0);
   endtask

   // Monitor: counts strobes, checks each newly presented result against the scoreboard.
   initial begin
      int   nld_n [2];
      int   nld_a [2];
      logic prev_v [2];
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         nld_n[d] = 0; nld_a[d] = 0; prev_v[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               nld_n[d] = 0; nld_a[d] = 0; prev_v[d] = 1'b0;
            end else begin
               if (dp_loadn[d]) nld_n[d]++;
               if (dp_loada[d]) nld_a[d]++;
               if (dp_loadn[d] && dp_loada[d]) chk("strobe_overlap", d, 1, 0);
               if (result_valid[d] && !prev_v[d]) begin
                  if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                     chk("unexpected_result", d, result[d], 32'hxxxx_xxxx);
                  end else begin
                     e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                     chk("result", d, result[d], e.res);
                     chk("result_cout", d, result_cout[d], e.cout);
                     chk("result_err", d, result_err[d], e.err);
                     chk("latency_cycle", d, cyc, e.cyc);
                     chk("dp_sub", d, dp_sub[d], e.sub);
                     chk("dp_a", d, dp_a[d], e.a);
                     chk("dp_b", d, dp_b[d], e.b);
                     chk("loadN_pulses", d, nld_n[d], 1);
                     chk("loadA_pulses", d, nld_a[d], e.n_loada);
                     chk("done_dp_en", d, dp_en[d], 0);
                  end
                  nld_n[d] = 0; nld_a[d] = 0;
               end
               prev_v[d] = result_valid[d];
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      start[0] = 1'b0;
      start[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", d, ready[d], 1);
         chk("rst_dp_en", d, dp_en[d], 0);
         chk("rst_valid", d, result_valid[d], 0);
         chk("rst_strobes", d, {dp_loadn[d], dp_loada[d]}, 0);
         chk("rst_dp_a", d, dp_a[d], 0);
         chk("rst_result", d, result[d], 0);
         chk("rst_err", d, result_err[d], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of NORM.
      a = 32'h3F80_0000; b = 32'h4000_0000; start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midnorm_dp_en", 0, dp_en[0], 1);
      rst = 1'b1;
      #1;
      chk("midrst_ready", 0, ready[0], 1);
      chk("midrst_dp_en", 0, dp_en[0], 0);
      chk("midrst_valid", 0, result_valid[0], 0);
      chk("midrst_strobes", 0, {dp_loadn[0], dp_loada[0]}, 0);
      chk("midrst_dp_a", 0, dp_a[0], 0);
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Add: 1.0 + 2.0 = 3.0, oe in 3rd NORM cycle.
      run_txn(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3, 32'h4040_0000, 0, 0, 1'b0,
              32'h4040_0000, 1'b0, 1'b0);
      do_ack(0);
      // Subtract: 3.0 - 1.0 = 2.0, with carry out.
      run_txn(0, 32'h4040_0000, 32'h3F80_0000, 1'b1, 1, 32'h4000_0000, 0, 0, 1'b1,
              32'h4000_0000, 1'b1, 1'b0);
      do_ack(0);
      // Watchdog: oe never arrives.
      run_txn(0, 32'h4120_0000, 32'h4130_0000, 1'b0, 0, 0, 0, 0, 1'b1,
              32'h0000_0000, 1'b0, 1'b1);
      do_ack(0);
      // oe on the final allowed NORM cycle wins.
      run_txn(0, 32'hC000_0000, 32'hC040_0000, 1'b0, 4, 32'hC0A0_0000, 0, 0, 1'b0,
              32'hC0A0_0000, 1'b0, 1'b0);
      do_ack(0);

      // Back-pressure: result held while start is pulsed with new operands.
      run_txn(0, 32'h4120_0000, 32'h3F00_0000, 1'b0, 2, 32'h4128_0000, 0, 0, 1'b0,
              32'h4128_0000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         a = 32'hDEAD_0000 + 32'(i); b = 32'hBEEF_0000; start[0] = ((i % 2) == 0);
         @(posedge clk); #1;
         start[0] = 1'b0;
         chk("bp_result", 0, result[0], 32'h4128_0000);
         chk("bp_dp_a", 0, dp_a[0], 32'h4120_0000);
         chk("bp_ready", 0, ready[0], 0);
         chk("bp_valid", 0, result_valid[0], 1);
      end
      // start coincident with the DONE-exit ack must be dropped.
      a = 32'hBAD0_0000; start[0] = 1'b1;
      do_ack(0);
      start[0] = 1'b0;
      chk("exit_start_ignored", 0, dp_a[0], 32'h4120_0000);
      @(posedge clk); #1;
      chk("exit_still_idle", 0, ready[0], 1);
      chk("exit_dp_a_held", 0, dp_a[0], 32'h4120_0000);
      run_txn(0, 32'h4080_0000, 32'h4080_0000, 1'b1, 2, 32'h0000_0000, 0, 0, 1'b0,
              32'h0000_0000, 1'b0, 1'b0);
      do_ack(0);

      // ADD_LAT=3: result is dp_sum from the 3rd ADD cycle.
      run_txn(1, 32'h40A0_0000, 32'h4000_0000, 1'b0, 2, 32'h1111_1111, 32'h2222_2222,
              32'h40E0_0000, 1'b1, 32'h40E0_0000, 1'b1, 1'b0);
      do_ack(1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb0_empty", 0, sb0.size(), 0);
      chk("sb1_empty", 1, sb1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
